mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, memory word width in bits; legal values 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter BE_W, default DATA_W/8, byte-enable width; derived, not overridden.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  accept a new access; sampled only in IDLE.
REQ-007 is_store  in  1  1 = store, 0 = load.
REQ-008 size  in  2  access size: 00 byte, 01 half, 10 word(32), 11 double(64).
REQ-009 sign_ext  in  1  load result sign-extended when 1, zero-extended when 0.
REQ-010 addr  in  ADDR_W  byte address of the access.
REQ-011 wdata  in  DATA_W  store data, right-justified.
REQ-012 busy  out  1  high from the cycle after an accepted start until done.
REQ-013 done  out  1  single-cycle completion pulse.
REQ-014 err  out  1  valid with done; access rejected, no memory write performed.
REQ-015 rdata  out  DATA_W  load result, right-justified and extended; held until the next done.
REQ-016 mem_req  out  1  memory request; held until mem_ack.
REQ-017 mem_we  out  1  write strobe, qualified by mem_req.
REQ-018 mem_addr  out  ADDR_W  word-aligned address (low log2(BE_W) bits zero).
REQ-019 mem_be  out  BE_W  byte lanes written or used.
REQ-020 mem_wdata  out  DATA_W  lane-aligned store data.
REQ-021 mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle.
REQ-022 mem_ack  in  1  memory completes the current beat.

Function
REQ-023 The FSM shall have states IDLE, BEAT0, BEAT1 and FIN; the encoding is free.
REQ-024 IDLE with start=1: latch all inputs and go to BEAT0, or go to FIN with err=1 when the access is illegal.
REQ-025 An access is illegal if size=11 with DATA_W=32, or if it is misaligned while MAU_MISALIGN_EN is undefined.
REQ-026 BEAT0 shall drive mem_req=1, and addr with its low bits cleared, for the first word; mem_be=((1<<nbytes)-1)<<offset, truncated to BE_W.
REQ-027 BEAT0 with mem_ack: go to BEAT1 if the access crosses a word boundary, otherwise go to FIN.
REQ-028 BEAT1 shall address word+1 with the remaining lanes starting at lane 0; mem_ack moves the FSM to FIN.
REQ-029 FIN shall pulse done for one cycle, update rdata for a legal load, then return to IDLE.
REQ-030 Latency, no wait states: an aligned access gives done 3 cycles after start; a split access gives done 4 cycles after start.
REQ-031 Store data shall be rotated left by offset*8 bits; the upper bytes wrapped into lane 0 are used by BEAT1.
REQ-032 Load bytes shall be gathered from both beats, right-justified, masked to nbytes, then extended per sign_ext from bit nbytes*8-1.
REQ-033 start shall be ignored while busy; mem_* outputs shall not change while mem_req=1 and mem_ack=0.
REQ-034 mem_ack outside BEAT0 or BEAT1 shall be ignored.

Reset
REQ-035 Reset shall force IDLE, busy=0, done=0, err=0, mem_req=0, mem_we=0, mem_be=0 and rdata=0, mem_addr=0, mem_wdata=0.
REQ-036 Reset mid-access shall abandon the access, with no done pulse; a pending mem_ack after reset is ignored per REQ-034.

Configuration
REQ-037 With macro MAU_MISALIGN_EN defined, a misaligned access shall be split per REQ-027/028.
REQ-038 With MAU_MISALIGN_EN undefined, BEAT1 shall be absent and any misaligned access shall complete with err=1 and mem_req never asserted.

Structure
REQ-039 A shared package shall hold the size encoding constants, the FSM state typedef and the function converting size to nbytes.
REQ-040 The sub-module mau_lane_align shall hold the combinational rotate, mask and extend logic; the FSM and registers shall stay in mem_access_unit.

Verification
REQ-041 DATA_W=32: load word from 0x100 with mem_rdata=0x8899AABB -> rdata=0x8899AABB, done 3 cycles after start, err=0.
REQ-042 Load byte from 0x103 with sign_ext=1, mem_rdata=0x80112233 -> mem_be=1000b, rdata=0xFFFFFF80; with sign_ext=0 -> rdata=0x00000080.
REQ-043 With MAU_MISALIGN_EN, store half 0xBEEF to 0x203 -> beat0 addr 0x200 be=1000b wdata[31:24]=0xEF; beat1 addr 0x204 be=0001b wdata[7:0]=0xBE; done 4 cycles after start.
REQ-044 Without MAU_MISALIGN_EN, load word from 0x202 -> err=1, done pulse, mem_req stays 0.
REQ-045 DATA_W=32 with size=11 -> err=1; DATA_W=64, load double from 0x8 -> mem_be=0xFF, single beat.
REQ-046 Assert reset while in BEAT0 with mem_ack held low -> next cycle all outputs at reset values; a later mem_ack produces no done.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: size codes, FSM states and
// the helper that turns a size code into a byte count.
package mem_access_unit_pkg;

  localparam logic [1:0] SIZE_BYTE   = 2'b00;
  localparam logic [1:0] SIZE_HALF   = 2'b01;
  localparam logic [1:0] SIZE_WORD   = 2'b10;
  localparam logic [1:0] SIZE_DOUBLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    FIN   = 2'd3
  } mau_state_t;

  function automatic logic [3:0] size_to_nbytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane steering for mem_access_unit: store rotation, byte-enable
// generation across two words, and load gather / mask / extension.
module mau_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8,
  localparam int OFF_W  = $clog2(BE_W)
) (
  input  logic [OFF_W-1:0]  offset,
  input  logic [3:0]        nbytes,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] lo_word,
  input  logic [DATA_W-1:0] hi_word,
  output logic [DATA_W-1:0] wdata_rot,
  output logic [BE_W-1:0]   be_lo,
  output logic [BE_W-1:0]   be_hi,
  output logic [DATA_W-1:0] load_data
);

  localparam logic [2*BE_W-1:0] BE_ONE = 1;

  logic [2*BE_W-1:0] be_full;
  logic [DATA_W-1:0] gathered;
  logic [DATA_W-1:0] mask;
  logic              sign_bit;
  logic [OFF_W-1:0]  src;
  logic [OFF_W:0]    pos;

  // Byte enables are computed over two adjacent words; the upper half is the
  // lane set of the second beat of a split access.
  always_comb begin
    be_full = (BE_ONE << nbytes) - BE_ONE;
    be_full = be_full << offset;
    be_lo   = be_full[BE_W-1:0];
    be_hi   = be_full[2*BE_W-1:BE_W];
  end

  always_comb begin
    wdata_rot = '0;
    gathered  = '0;
    mask      = '0;
    sign_bit  = 1'b0;
    src       = '0;
    pos       = '0;
    for (int i = 0; i < BE_W; i++) begin
      src = OFF_W'(i) - offset;
      wdata_rot[8*i +: 8] = wdata[8*src +: 8];
      // Result byte i comes from byte i+offset of the {hi,lo} word pair.
      pos = (OFF_W+1)'(i) + {1'b0, offset};
      gathered[8*i +: 8] = pos[OFF_W] ? hi_word[8*pos[OFF_W-1:0] +: 8]
                                      : lo_word[8*pos[OFF_W-1:0] +: 8];
      mask[8*i +: 8] = (4'(i) < nbytes) ? 8'hFF : 8'h00;
      if (4'(i + 1) == nbytes) sign_bit = gathered[8*i + 7];
    end
    load_data = (gathered & mask) | ((sign_ext && sign_bit) ? ~mask : '0);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/half/word/double load-store unit in front of a word-wide memory port.
// Define MAU_MISALIGN_EN to split word-crossing accesses into two beats.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int OFF_W = $clog2(BE_W);
`ifdef MAU_MISALIGN_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  mau_state_t state, state_next;

  logic              store_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] hi_q;

  logic [3:0]        in_nbytes;
  logic              in_misaligned;
  logic              in_illegal;
  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] wdata_rot;
  logic [BE_W-1:0]   be_lo;
  logic [BE_W-1:0]   be_hi;
  logic [DATA_W-1:0] load_data;
  logic              crossing;

  // Legality is judged on the raw inputs so an illegal access never reaches BEAT0.
  always_comb begin
    in_nbytes     = size_to_nbytes(size);
    in_misaligned = |(addr[OFF_W-1:0] & OFF_W'(in_nbytes - 4'd1));
    in_illegal    = ((size == SIZE_DOUBLE) && (DATA_W == 32)) ||
                    (!SPLIT_EN && in_misaligned);
  end

  assign word_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign crossing  = |be_hi;

  mau_lane_align #(.DATA_W(DATA_W)) u_align (
    .offset   (addr_q[OFF_W-1:0]),
    .nbytes   (size_to_nbytes(size_q)),
    .sign_ext (sign_q),
    .wdata    (wdata_q),
    .lo_word  (lo_q),
    .hi_word  (hi_q),
    .wdata_rot(wdata_rot),
    .be_lo    (be_lo),
    .be_hi    (be_hi),
    .load_data(load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Memory-side outputs depend only on state and latched fields, so they hold
  // steady through any number of wait states.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: if (start) state_next = in_illegal ? FIN : BEAT0;
      BEAT0: begin
        mem_req   = 1'b1;
        mem_we    = store_q;
        mem_addr  = word_addr;
        mem_be    = be_lo;
        mem_wdata = wdata_rot;
        if (mem_ack) state_next = (SPLIT_EN && crossing) ? BEAT1 : FIN;
      end
`ifdef MAU_MISALIGN_EN
      BEAT1: begin
        mem_req   = 1'b1;
        mem_we    = store_q;
        mem_addr  = word_addr + ADDR_W'(BE_W);
        mem_be    = be_hi;
        mem_wdata = wdata_rot;
        if (mem_ack) state_next = FIN;
      end
`endif
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      store_q <= 1'b0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy    <= 1'b1;
          store_q <= is_store;
          size_q  <= size;
          sign_q  <= sign_ext;
          addr_q  <= addr;
          wdata_q <= wdata;
          err_q   <= in_illegal;
        end
        BEAT0: if (mem_ack) lo_q <= mem_rdata;
`ifdef MAU_MISALIGN_EN
        BEAT1: if (mem_ack) hi_q <= mem_rdata;
`endif
        FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
          err  <= err_q;
          if (!err_q && !store_q) rdata <= load_data;
        end
        default: ;
      endcase
    end
  end

endmodule
